// File: rtl/store_rmw_if.sv
// Bundles the store request side and the word-wide data memory port of store_rmw_unit.
interface store_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              done;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic              mem_wack;

    // The store unit itself.
    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_rvalid, mem_wack,
        output req_ready, done, misaligned, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    // Datapath plus memory model driving the unit.
    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata, mem_rvalid, mem_wack,
        input  req_ready, done, misaligned, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/store_rmw_unit.sv
// Byte/half/word store engine for a memory without byte enables: sub-word stores
// become read-merge-write of the containing word; misaligned requests are rejected.
module store_rmw_unit #(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    store_rmw_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic [15:0]       r_data;
    logic [31:0]       r_wdata;
    logic              r_mis;
    logic              w_accept;
    logic              w_bad;

    // Little-endian lane merge of the narrow store data into the word just read.
    function automatic logic [31:0] merge_word(input logic [31:0] rd, input logic [15:0] d,
                                               input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] w;
        w = rd;
        if (sz == SZ_BYTE) begin
            case (off)
                2'd0:    w[7:0]   = d[7:0];
                2'd1:    w[15:8]  = d[7:0];
                2'd2:    w[23:16] = d[7:0];
                default: w[31:24] = d[7:0];
            endcase
        end else if (off[1]) begin
            w[31:16] = d;
        end else begin
            w[15:0] = d;
        end
        return w;
    endfunction

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_bad    = (bus.req_size == 2'b11)
                   || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                   || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_bad)                        w_next = DONE;
                    else if (bus.req_size == SZ_WORD) w_next = WRITE;
                    else                              w_next = READ;
                end
            end
            READ:    if (bus.mem_rvalid) w_next = WRITE;
            WRITE:   if (bus.mem_wack)   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture and write-word assembly; data held stable while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_data     <= '0;
            r_wdata    <= '0;
            r_mis      <= 1'b0;
        end else if (w_accept) begin
            r_mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            r_off      <= bus.req_addr[1:0];
            r_size     <= bus.req_size;
            r_data     <= bus.req_data[15:0];
            r_mis      <= w_bad;
            if (bus.req_size == SZ_WORD) r_wdata <= bus.req_data;
        end else if ((r_state == READ) && bus.mem_rvalid) begin
            r_wdata <= merge_word(bus.mem_rdata, r_data, r_off, r_size);
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.mem_rd     = (r_state == READ);
    assign bus.mem_wr     = (r_state == WRITE);
    assign bus.done       = (r_state == DONE);
    assign bus.misaligned = (r_state == DONE) && r_mis;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_wdata;
endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Store-path counterpart to the load-path extension logic: accepts a byte, halfword or word store from the datapath and writes it into a word-wide data memory that has no byte enables. Sub-word stores use a read-modify-write sequence: read the containing word, merge the narrow data into the correct lane, then write the word back. The block sits between the MIPS datapath (SB/SH/SW) and the data memory port. It provides a simple valid/ready request side and a read/write handshake memory side.

## Interface
- ADDR_W, 32, byte-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  block idle; request accepted on a cycle with req_valid && req_ready
- req_addr  in  ADDR_W  byte address
- req_data  in  32  store data; the low byte or halfword is used for sub-word stores
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- done  out  1  one-cycle completion pulse
- misaligned  out  1  valid with done; 1 = request rejected, no memory access
- mem_addr  out  ADDR_W  word address, bits [1:0] always 0
- mem_rd  out  1  read request, held until mem_rvalid
- mem_rdata  in  32  read data, valid with mem_rvalid
- mem_rvalid  in  1  read data valid
- mem_wr  out  1  write request, held until mem_wack
- mem_wdata  out  32  merged write word
- mem_wack  in  1  write accepted

## Operation
- FSM states: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state; none depends combinationally on the mem_* inputs.
- IDLE: req_ready=1. On acceptance, capture addr, data and size. Next state:
  - illegal size, half with addr[0]=1, or word with addr[1:0]!=0: DONE with misaligned=1.
  - word: WRITE, with mem_wdata = req_data.
  - byte or half: READ.
- READ: mem_rd=1. When mem_rvalid=1, latch the merged word into mem_wdata and go to WRITE.
- WRITE: mem_wr=1. When mem_wack=1, go to DONE with misaligned=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Merge is little-endian:
  - byte: lane addr[1:0] replaced by data[7:0].
  - half: lane addr[1] (bits [15:0] or [31:16]) replaced by data[15:0].
  - all other bits come from mem_rdata.
- mem_addr = {addr[ADDR_W-1:2], 2'b00}. It is stable from the cycle after acceptance through the last WRITE cycle.
- mem_rvalid is ignored outside READ; mem_wack is ignored outside WRITE.
- req_valid is ignored while not in IDLE. No queueing.

## Timing
- Reset values: state IDLE, req_ready=1, done=0, misaligned=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Cycle numbering: request accepted in cycle 0.
- Word, wack in cycle k≥1: mem_wr high cycles 1..k, done in cycle k+1, req_ready=1 in cycle k+2.
- Sub-word, rvalid in cycle r≥1 and wack in cycle w≥r+1: mem_rd high cycles 1..r, mem_wr high cycles r+1..w, done in cycle w+1.
- Minimum latencies (request to done): word 2 cycles, sub-word 3 cycles, rejected request 1 cycle (done+misaligned in cycle 1).
- mem_rd and mem_wr are never high in the same cycle.
- rvalid/wack arriving in the first cycle of READ/WRITE are honoured; there is no minimum stall.
- rst_n low mid-operation (any state):
  - immediate return to IDLE and reset output values, independent of the clock.
  - no done pulse; the in-flight store is dropped.
  - memory must tolerate an abandoned rd/wr.
- Back-to-back: a new request is accepted in the first IDLE cycle after DONE, giving a throughput of one store per latency+1 cycles.

## Test plan
- Word store, addr 0x10, data 0xDEADBEEF, wack in cycle 1:
  - mem_wr=1 in cycle 1 only, with mem_addr=0x10 and mem_wdata=0xDEADBEEF.
  - mem_rd never asserted; done=1, misaligned=0 in cycle 2.
- Byte store, addr 0x23, data 0x000000AB, memory returns 0x11223344 with rvalid in cycle 3:
  - mem_rd high cycles 1–3, mem_addr=0x20.
  - mem_wdata=0xAB223344.
  - done one cycle after wack.
- Half store, addr 0x42, data 0xFFFFBEEF, memory returns 0x11223344:
  - mem_wdata=0xBEEF3344.
  - Repeat at addr 0x40: mem_wdata=0x1122BEEF.
- Rejection cases, each with no mem_rd and no mem_wr:
  - half at addr 0x01: done=1, misaligned=1 in cycle 1.
  - word at addr 0x02: same response.
  - size 11: same response.
- Reset during READ, with rvalid withheld, rst_n pulsed low for 2 cycles:
  - mem_rd drops asynchronously; req_ready=1.
  - no done, no mem_wr afterwards.
  - the next word store completes normally.
- req_valid held high across two different requests:
  - the second request is accepted only in the IDLE cycle after DONE.
  - its address and data are not corrupted by changes on the req_* inputs while the block is busy.
